// File: rtl/seven_seg_if.sv
// Host load channel for seven_seg_scanner: valid/ready handshake carrying
// one BCD nibble per digit.
interface seven_seg_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic                  ready;

    modport master (output load, output value, input ready);
    modport slave  (input load, input value, output ready);
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment scan controller with dead time and
// frame-aligned value updates. Optional leading-zero blanking: SEVENSEG_LZB_EN.
module seven_seg_scanner #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    seven_seg_if.slave        bus,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg
);
    localparam int unsigned VW   = 4 * DIGITS;
    localparam int unsigned MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int unsigned IW   = $clog2(DIGITS);

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [VW-1:0]   active;
    logic [VW-1:0]   shadow;
    logic            pending;
    logic            ready;

    assign bus.ready = ready;

    // Segment pattern for digit i of val; non-BCD nibbles show as zero.
    function automatic logic [6:0] digit_seg(input logic [VW-1:0] val, input logic [IW-1:0] i);
        logic [3:0] nib;
        logic [6:0] s;
        nib = val[4*i +: 4];
        case (nib)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b1111110;
        endcase
`ifdef SEVENSEG_LZB_EN
        if (i != '0 && (val >> (4*i)) == '0) s = 7'b0000000;
`endif
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BLANK;
            cnt     <= '0;
            idx     <= '0;
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            ready   <= 1'b1;
            an      <= '0;
            seg     <= '0;
        end else begin
            // Capture only happens with pending clear, so it never collides with a transfer.
            if (bus.load && ready) begin
                shadow  <= bus.value;
                pending <= 1'b1;
                ready   <= 1'b0;
            end

            if (!en) begin
                state <= BLANK;
                cnt   <= '0;
                idx   <= '0;
                an    <= '0;
                seg   <= '0;
                if (pending) begin
                    active  <= shadow;
                    pending <= 1'b0;
                    ready   <= 1'b1;
                end
            end else begin
                case (state)
                    BLANK: begin
                        if (cnt == CW'(BLANK_CYCLES - 1)) begin
                            state <= ON;
                            cnt   <= '0;
                            an    <= DIGITS'(1) << idx;
                            seg   <= digit_seg(active, idx);
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ON: begin
                        if (cnt == CW'(REFRESH_DIV - 1)) begin
                            state <= BLANK;
                            cnt   <= '0;
                            an    <= '0;
                            seg   <= '0;
                            // Last lit cycle of the final digit is the frame boundary.
                            if (idx == IW'(DIGITS - 1)) begin
                                idx <= '0;
                                if (pending) begin
                                    active  <= shadow;
                                    pending <= 1'b0;
                                    ready   <= 1'b1;
                                end
                            end else begin
                                idx <= idx + IW'(1);
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: state <= BLANK;
                endcase
            end
        end
    end
endmodule
